// File: rtl/sigma_muldiv_unit_if.sv
// sigma_muldiv_unit_if: request/result handshake bundle for the M-extension unit.
//   in_valid/in_ready   - request handshake (requester -> unit)
//   in_op               - RISC-V funct3 of the M op
//   in_a/in_b           - rs1/rs2 operands
//   out_valid/out_ready - result handshake (unit -> consumer)
//   out_result          - XLEN-bit result
// master: pipeline side driving requests; slave: the muldiv unit.
interface sigma_muldiv_unit_if #(
    parameter int unsigned XLEN = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [2:0]      in_op;
    logic [XLEN-1:0] in_a;
    logic [XLEN-1:0] in_b;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_result;

    modport master (
        output in_valid, in_op, in_a, in_b, out_ready,
        input  in_ready, out_valid, out_result
    );

    modport slave (
        input  in_valid, in_op, in_a, in_b, out_ready,
        output in_ready, out_valid, out_result
    );
endinterface

// File: rtl/sigma_muldiv_unit.sv
// sigma_muldiv_unit: iterative RV32M/RV64M multiply/divide unit.
//   clk   - rising-edge clock
//   rst   - synchronous active-high reset (highest priority)
//   flush - synchronous kill of any in-flight or pending operation
//   bus   - sigma_muldiv_unit_if slave: request valid/ready, op, operands,
//           result valid/ready, result
// Multiplies use radix-2 shift-add, divides restoring shift-subtract, one bit
// per cycle on operand magnitudes; sign is fixed up on the last iteration.
// Divide-by-zero and signed overflow bypass the iteration and finish in one cycle.
module sigma_muldiv_unit #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned CNT_W = $clog2(XLEN) + 1
) (
    input logic               clk,
    input logic               rst,
    input logic               flush,
    sigma_muldiv_unit_if.slave bus
);
    typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

    localparam logic [XLEN-1:0] MsbOnly = {1'b1, {(XLEN-1){1'b0}}};

    state_e              state_q;
    logic [2:0]          op_q;
    logic [2*XLEN-1:0]   acc_q;      // {hi, lo}: product, or {remainder, quotient}
    logic [XLEN-1:0]     opnd_q;     // multiplicand or divisor magnitude
    logic [XLEN-1:0]     res_q;
    logic                neg_q;
    logic                special_q;  // acc_q low half already holds the final result
    logic [CNT_W-1:0]    cnt_q;

    // Accept-side decode.
    logic            is_div, a_sgn, b_sgn, a_neg, b_neg, neg_start;
    logic            div0, ovf, special;
    logic [XLEN-1:0] a_mag, b_mag, special_res;

    always_comb begin
        is_div    = bus.in_op[2];
        a_sgn     = is_div ? ~bus.in_op[0] : (bus.in_op == 3'b001 || bus.in_op == 3'b010);
        b_sgn     = is_div ? ~bus.in_op[0] : (bus.in_op == 3'b001);
        a_neg     = a_sgn & bus.in_a[XLEN-1];
        b_neg     = b_sgn & bus.in_b[XLEN-1];
        a_mag     = a_neg ? -bus.in_a : bus.in_a;
        b_mag     = b_neg ? -bus.in_b : bus.in_b;
        // Remainder takes the dividend's sign; everything else the xor.
        neg_start = (is_div && bus.in_op[1]) ? a_neg : (a_neg ^ b_neg);
        div0      = is_div && (bus.in_b == '0);
        ovf       = is_div && !bus.in_op[0] && (bus.in_a == MsbOnly) && (bus.in_b == '1);
        special   = div0 || ovf;
        if (div0) begin
            special_res = bus.in_op[1] ? bus.in_a : '1;
        end else begin
            special_res = bus.in_op[1] ? '0 : bus.in_a;
        end
    end

    // One iteration step and final result formation.
    logic [XLEN:0]     mul_sum, div_rem, div_diff;
    logic [2*XLEN-1:0] mul_nxt, div_nxt, acc_nxt, prod_fix;
    logic [XLEN-1:0]   div_sel, final_res;

    always_comb begin
        mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + {1'b0, (acc_q[0] ? opnd_q : '0)};
        mul_nxt  = {mul_sum, acc_q[XLEN-1:1]};
        div_rem  = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
        div_diff = div_rem - {1'b0, opnd_q};
        // Negative trial difference means restore: keep shifted remainder, quotient bit 0.
        if (div_diff[XLEN]) begin
            div_nxt = {div_rem[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
        end else begin
            div_nxt = {div_diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
        end
        acc_nxt  = op_q[2] ? div_nxt : mul_nxt;
        prod_fix = neg_q ? -acc_nxt : acc_nxt;
        div_sel  = op_q[1] ? acc_nxt[2*XLEN-1:XLEN] : acc_nxt[XLEN-1:0];
        if (op_q[2]) begin
            final_res = neg_q ? -div_sel : div_sel;
        end else if (op_q[1:0] == 2'b00) begin
            final_res = prod_fix[XLEN-1:0];
        end else begin
            final_res = prod_fix[2*XLEN-1:XLEN];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            op_q      <= '0;
            acc_q     <= '0;
            opnd_q    <= '0;
            res_q     <= '0;
            neg_q     <= 1'b0;
            special_q <= 1'b0;
            cnt_q     <= '0;
        end else if (flush) begin
            state_q <= StIdle;
        end else begin
            case (state_q)
                StIdle: begin
                    if (bus.in_valid) begin
                        op_q      <= bus.in_op;
                        neg_q     <= neg_start;
                        special_q <= special;
                        cnt_q     <= '0;
                        state_q   <= StCalc;
                        opnd_q    <= is_div ? b_mag : a_mag;
                        if (special) begin
                            acc_q <= {{XLEN{1'b0}}, special_res};
                        end else begin
                            acc_q <= {{XLEN{1'b0}}, (is_div ? a_mag : b_mag)};
                        end
                    end
                end
                StCalc: begin
                    if (special_q) begin
                        res_q   <= acc_q[XLEN-1:0];
                        state_q <= StDone;
                    end else begin
                        acc_q <= acc_nxt;
                        cnt_q <= cnt_q + 1'b1;
                        if (cnt_q == CNT_W'(XLEN - 1)) begin
                            res_q   <= final_res;
                            state_q <= StDone;
                        end
                    end
                end
                StDone: begin
                    if (bus.out_ready) begin
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.in_ready   = (state_q == StIdle);
    assign bus.out_valid  = (state_q == StDone);
    assign bus.out_result = res_q;
endmodule

// File: tb/tb_sigma_muldiv_unit.sv
// tb_sigma_muldiv_unit: directed and corner-operand checks of sigma_muldiv_unit
// at XLEN=32 and XLEN=64, sharing one clock, reset and flush.
module tb_sigma_muldiv_unit;
    logic clk = 1'b0;
    logic rst, flush;
    always #5 clk = ~clk;

    logic        req_valid, rdy, target;  // target: 0 -> 32-bit DUT, 1 -> 64-bit DUT
    logic [2:0]  req_op;
    logic [63:0] req_a, req_b;
    logic        obs_valid, obs_ready;
    logic [63:0] obs_result;

    int checks = 0;
    int errors = 0;

    sigma_muldiv_unit_if #(.XLEN(32)) if32 ();
    sigma_muldiv_unit_if #(.XLEN(64)) if64 ();

    sigma_muldiv_unit #(.XLEN(32)) dut32 (.clk(clk), .rst(rst), .flush(flush), .bus(if32));
    sigma_muldiv_unit #(.XLEN(64)) dut64 (.clk(clk), .rst(rst), .flush(flush), .bus(if64));

    assign if32.in_valid  = req_valid & ~target;
    assign if32.in_op     = req_op;
    assign if32.in_a      = req_a[31:0];
    assign if32.in_b      = req_b[31:0];
    assign if32.out_ready = rdy & ~target;
    assign if64.in_valid  = req_valid & target;
    assign if64.in_op     = req_op;
    assign if64.in_a      = req_a;
    assign if64.in_b      = req_b;
    assign if64.out_ready = rdy & target;

    assign obs_valid  = target ? if64.out_valid : if32.out_valid;
    assign obs_ready  = target ? if64.in_ready : if32.in_ready;
    assign obs_result = target ? if64.out_result : {32'd0, if32.out_result};

    function automatic logic [63:0] mask_of(input int xl);
        return (xl == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
    endfunction

    function automatic logic [63:0] msb_of(input int xl);
        return (xl == 64) ? 64'h8000_0000_0000_0000 : 64'h0000_0000_8000_0000;
    endfunction

    // Reference: wide signed arithmetic on sign/zero-extended operands.
    function automatic logic [63:0] ref_model(input int xl, input logic [2:0] op,
                                              input logic [63:0] a_in, input logic [63:0] b_in);
        logic [63:0] m, a, b;
        logic signed [129:0] ua, ub, sa, sb, p;
        logic ovf;
        m   = mask_of(xl);
        a   = a_in & m;
        b   = b_in & m;
        ua  = $signed({66'd0, a});
        ub  = $signed({66'd0, b});
        sa  = ((a & msb_of(xl)) != 64'd0) ? ua - (130'sd1 <<< xl) : ua;
        sb  = ((b & msb_of(xl)) != 64'd0) ? ub - (130'sd1 <<< xl) : ub;
        ovf = (a == msb_of(xl)) && (b == m);
        case (op)
            3'd0: begin p = sa * sb; return p[63:0] & m; end
            3'd1: begin p = sa * sb; return 64'(p >>> xl) & m; end
            3'd2: begin p = sa * ub; return 64'(p >>> xl) & m; end
            3'd3: begin p = ua * ub; return 64'(p >>> xl) & m; end
            3'd4: begin
                if (b == 64'd0) return m;
                if (ovf) return a;
                p = sa / sb; return p[63:0] & m;
            end
            3'd5: begin
                if (b == 64'd0) return m;
                p = ua / ub; return p[63:0] & m;
            end
            3'd6: begin
                if (b == 64'd0) return a;
                if (ovf) return 64'd0;
                p = sa % sb; return p[63:0] & m;
            end
            default: begin
                if (b == 64'd0) return a;
                p = ua % ub; return p[63:0] & m;
            end
        endcase
    endfunction

    // Issue one op, measure latency, hold backpressure for 'stall' cycles, then retire it.
    task automatic do_op(input int xl, input logic [2:0] op, input logic [63:0] a,
                         input logic [63:0] b, input logic [63:0] exp_res, input int exp_lat,
                         input int stall, input string name);
        int k;
        logic [63:0] held;
        target = (xl == 64);
        req_op = op;
        req_a  = a;
        req_b  = b;
        rdy    = 1'b0;
        #1;
        k = 0;
        while (!obs_ready && k < 200) begin
            @(posedge clk); #1; k++;
        end
        checks++;
        if (obs_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s in_ready before accept: got %b expected 1", name, obs_ready);
        end
        req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        k = 0;
        while (!obs_valid && k < xl + 8) begin
            @(posedge clk); #1; k++;
        end
        checks++;
        if (obs_valid !== 1'b1 || k != exp_lat) begin
            errors++;
            $display("FAIL %s latency: got %0d (valid=%b) expected %0d", name, k, obs_valid,
                     exp_lat);
        end
        checks++;
        if (obs_result !== exp_res) begin
            errors++;
            $display("FAIL %s result: got %h expected %h", name, obs_result, exp_res);
        end
        held = obs_result;
        for (int s = 0; s < stall; s++) begin
            @(posedge clk); #1;
            checks++;
            if (obs_valid !== 1'b1 || obs_ready !== 1'b0 || obs_result !== held) begin
                errors++;
                $display("FAIL %s stall %0d: got valid=%b ready=%b res=%h expected 1 0 %h",
                         name, s, obs_valid, obs_ready, obs_result, held);
            end
        end
        rdy = 1'b1;
        @(posedge clk); #1;
        rdy = 1'b0;
        checks++;
        if (obs_valid !== 1'b0 || obs_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s retire: got valid=%b ready=%b expected 0 1", name, obs_valid,
                     obs_ready);
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; flush = 1'b0; req_valid = 1'b0; rdy = 1'b0; target = 1'b0;
        req_op = 3'd0; req_a = 64'd0; req_b = 64'd0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        checks++;
        if (if32.in_ready !== 1'b1 || if32.out_valid !== 1'b0 || if32.out_result !== 32'd0) begin
            errors++;
            $display("FAIL reset32: got ready=%b valid=%b res=%h expected 1 0 0",
                     if32.in_ready, if32.out_valid, if32.out_result);
        end
        checks++;
        if (if64.in_ready !== 1'b1 || if64.out_valid !== 1'b0 || if64.out_result !== 64'd0) begin
            errors++;
            $display("FAIL reset64: got ready=%b valid=%b res=%h expected 1 0 0",
                     if64.in_ready, if64.out_valid, if64.out_result);
        end
    endtask

    task automatic test_mul;
        do_op(32, 3'd0, 64'h7, 64'hFFFF_FFFD, 64'hFFFF_FFEB, 32, 0, "mul_7xm3");
        do_op(32, 3'd3, 64'hFFFF_FFFF, 64'hFFFF_FFFF, 64'hFFFF_FFFE, 32, 0, "mulhu_ones");
        do_op(32, 3'd1, 64'h8000_0000, 64'h8000_0000, 64'h4000_0000, 32, 0, "mulh_msb");
        do_op(32, 3'd2, 64'hFFFF_FFFF, 64'hFFFF_FFFF, 64'hFFFF_FFFF, 32, 0, "mulhsu_ones");
        do_op(64, 3'd1, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000,
              64'h4000_0000_0000_0000, 64, 0, "mulh64_msb");
    endtask

    task automatic test_div;
        do_op(32, 3'd4, 64'hFFFF_FFF9, 64'h2, 64'hFFFF_FFFD, 32, 0, "div_m7_2");
        do_op(32, 3'd6, 64'hFFFF_FFF9, 64'h2, 64'hFFFF_FFFF, 32, 0, "rem_m7_2");
        do_op(32, 3'd5, 64'd100, 64'd7, 64'd14, 32, 0, "divu_100_7");
        do_op(32, 3'd7, 64'd100, 64'd7, 64'd2, 32, 0, "remu_100_7");
        do_op(64, 3'd4, 64'hFFFF_FFFF_FFFF_FFF9, 64'h2, 64'hFFFF_FFFF_FFFF_FFFD, 64, 0,
              "div64_m7_2");
    endtask

    task automatic test_special;
        do_op(32, 3'd5, 64'd5, 64'd0, 64'hFFFF_FFFF, 1, 0, "divu_by0");
        do_op(32, 3'd7, 64'd5, 64'd0, 64'd5, 1, 0, "remu_by0");
        do_op(32, 3'd4, 64'h8000_0000, 64'hFFFF_FFFF, 64'h8000_0000, 1, 0, "div_ovf");
        do_op(32, 3'd6, 64'h8000_0000, 64'hFFFF_FFFF, 64'd0, 1, 0, "rem_ovf");
    endtask

    task automatic test_backpressure;
        do_op(32, 3'd3, 64'hFFFF_FFFF, 64'hFFFF_FFFF, 64'hFFFF_FFFE, 32, 5, "bp_mulhu");
    endtask

    task automatic test_flush;
        int seen;
        target = 1'b0; req_op = 3'd5; req_a = 64'd100; req_b = 64'd7; rdy = 1'b1;
        // Handshake coinciding with flush is discarded.
        req_valid = 1'b1; flush = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0; flush = 1'b0;
        checks++;
        if (if32.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL flush_accept: got in_ready=%b expected 1", if32.in_ready);
        end
        req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        repeat (9) @(posedge clk);
        #1 flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        checks++;
        if (if32.in_ready !== 1'b1 || if32.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL flush_calc: got ready=%b valid=%b expected 1 0", if32.in_ready,
                     if32.out_valid);
        end
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (if32.out_valid === 1'b1) seen++;
        end
        rdy = 1'b0;
        checks++;
        if (seen != 0) begin
            errors++;
            $display("FAIL flush_novalid: got %0d valid cycles expected 0", seen);
        end
        do_op(32, 3'd0, 64'd3, 64'd4, 64'd12, 32, 0, "mul_after_flush");
    endtask

    task automatic test_reset_mid;
        target = 1'b0; req_op = 3'd0; req_a = 64'd7; req_b = 64'd7; rdy = 1'b0;
        req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        checks++;
        if (if32.in_ready !== 1'b1 || if32.out_valid !== 1'b0 || if32.out_result !== 32'd0) begin
            errors++;
            $display("FAIL reset_mid: got ready=%b valid=%b res=%h expected 1 0 0",
                     if32.in_ready, if32.out_valid, if32.out_result);
        end
    endtask

    function automatic logic [63:0] pick(input int xl, input int k);
        case (k)
            0: return 64'd0;
            1: return 64'd1;
            2: return mask_of(xl);
            3: return msb_of(xl);
            4: return {32'($urandom), 32'($urandom)} & mask_of(xl);
            default: return 64'($urandom_range(0, 20));
        endcase
    endfunction

    task automatic test_back_to_back;
        logic [2:0] op;
        logic [63:0] a, b, m;
        int lat, xl;
        for (int pass = 0; pass < 2; pass++) begin
            xl = (pass == 0) ? 32 : 64;
            m  = mask_of(xl);
            for (int i = 0; i < 48; i++) begin
                op = 3'(i % 8);
                a  = pick(xl, $urandom_range(0, 5));
                b  = pick(xl, $urandom_range(0, 5));
                lat = (op[2] && (b == 64'd0 || (!op[0] && a == msb_of(xl) && b == m))) ? 1 : xl;
                do_op(xl, op, a, b, ref_model(xl, op, a, b), lat, $urandom_range(0, 2),
                      "rand");
            end
        end
    endtask

    initial begin
        test_reset();
        test_mul();
        test_div();
        test_special();
        test_backpressure();
        test_flush();
        test_reset_mid();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/sigma_muldiv_unit.md
Name: sigma_muldiv_unit

Overview:
- Iterative RV32M/RV64M multiply/divide unit; a parametrised, multi-cycle successor to the single-cycle ALU op set.
- Executes the eight M-extension ops (op encoding = RISC-V funct3) over XLEN-bit operands.
- Sits beside the ALU in EX. Valid/ready on both sides lets the pipeline stall on busy and on result backpressure.

Parameters:
- XLEN, 32, operand/result width; must be even and >= 8.
- CNT_W, $clog2(XLEN)+1, iteration counter width (derived; do not override).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- flush  in  1  synchronous kill of any in-flight or pending operation.
- in_valid  in  1  request valid.
- in_ready  out  1  unit can accept a request (state == IDLE).
- in_op  in  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- in_a  in  XLEN  rs1 operand (dividend / multiplicand).
- in_b  in  XLEN  rs2 operand (divisor / multiplier).
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- out_result  out  XLEN  result.

Behaviour:
- Reset (rst=1 at an edge):
  - State goes to IDLE; out_valid=0, out_result=0, counter=0, internal regs cleared.
  - in_ready=1 from the first cycle after reset.
  - rst has priority over flush and over both handshakes.
- States: IDLE, CALC, DONE.
  - in_ready is high only in IDLE.
  - out_valid is high only in DONE.
- Accept: on an edge with in_valid & in_ready (call it edge t0), latch op and operands, then:
  - Special case (see below): go straight to DONE with the result. out_valid is visible after edge t0+1 (1-cycle latency).
  - Otherwise: go to CALC with counter=0.
- CALC:
  - Signed operands are converted to magnitudes; result sign is recorded at accept.
  - Multiply: radix-2 shift-add on a 2*XLEN-bit accumulator, one multiplier bit per edge.
  - Divide: restoring shift-subtract, one quotient bit per edge.
  - XLEN iterations on edges t0+1 .. t0+XLEN.
  - Sign correction (two's-complement negate where required) and result select happen on edge t0+XLEN, which also enters DONE. out_valid is therefore high from the cycle after edge t0+XLEN (latency XLEN cycles).
- Result select:
  - MUL: low XLEN bits of the product.
  - MULH: high XLEN, signed x signed.
  - MULHSU: high XLEN, signed rs1 x unsigned rs2.
  - MULHU: high XLEN, unsigned x unsigned.
  - DIV/DIVU: quotient, truncating toward zero.
  - REM/REMU: remainder; its sign equals the dividend's sign.
- Special cases (1-cycle path):
  - Divide by zero (in_b==0, any div/rem op): DIV/DIVU give all-ones; REM/REMU give in_a.
  - Signed overflow (DIV/REM with in_a = 1<<(XLEN-1) and in_b = all-ones): DIV gives in_a; REM gives 0.
  - Multiplies have no special case.
- DONE:
  - out_result and out_valid hold stable while out_ready=0. No new request is accepted.
  - On an edge with out_valid & out_ready, go to IDLE and clear out_valid. out_result holds its last value.
  - No same-edge turnaround: the next accept happens at the earliest one edge later, since in_ready=0 in DONE.
- flush=1 at an edge:
  - Go to IDLE and clear out_valid, from any state.
  - A handshake coinciding with flush is discarded.
  - A result in DONE is dropped even if out_ready=1 on the same edge.
- Operand regs are sampled only at accept; input changes during CALC/DONE have no effect.
- in_op is a full 3-bit decode; there are no illegal codes.

Test Plan:
- MUL 7 x 0xFFFFFFFD (-3), XLEN=32: out_valid 32 cycles after accept, result 0xFFFFFFEB. MULHU 0xFFFFFFFF x 0xFFFFFFFF gives 0xFFFFFFFE. MULH 0x80000000 x 0x80000000 gives 0x40000000. MULHSU 0xFFFFFFFF x 0xFFFFFFFF gives 0xFFFFFFFF.
- DIV 0xFFFFFFF9 (-7) / 2 gives 0xFFFFFFFD. REM of the same gives 0xFFFFFFFF. DIVU 100/7 gives 14. REMU 100/7 gives 2. Each has 32-cycle latency.
- DIVU 5/0 gives 0xFFFFFFFF and REMU 5/0 gives 5, both 1 cycle after accept. DIV 0x80000000 / 0xFFFFFFFF gives 0x80000000 and REM of the same gives 0, both at 1-cycle latency.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid. out_result stays stable and in_ready stays 0 throughout. Raising out_ready completes the handshake; in_ready=1 on the next cycle.
- flush at CALC iteration 10: IDLE next cycle and out_valid never asserts. A following MUL 3x4 returns 12. Separately, assert rst mid-CALC: all outputs take their reset values after that edge.
- Randomised back-to-back ops at XLEN=32 and XLEN=64 with random out_ready, checked against a reference model, including operands 0, 1, all-ones and MSB-only.
